// File: rtl/display_scan_ctrl_pkg.sv
// rtl/display_scan_ctrl_pkg.sv - shared types and constants for the display scan controller
package display_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_COMMIT
  } scan_state_t;

  localparam logic [3:0] DIG_DASH = 4'd15;
  localparam logic [3:0] DIG_ZERO = 4'd0;

  // Decimal digits needed for the magnitude of a signed value of the given width
  // (log10(2) ~ 0.301, plus one for the partial digit).
  function automatic int bcd_digits(input int width);
    return (width * 301) / 1000 + 1;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// rtl/display_scan_ctrl_if.sv - value input handshake and display drive signals
interface display_scan_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int NDIG  = 8
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             busy;
  logic [3:0]       digito;
  logic [NDIG-1:0]  anode;

  // Source of values to display (e.g. the multiplier side)
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  busy,
    input  digito,
    input  anode
  );

  // The scan controller itself
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output busy,
    output digito,
    output anode
  );

endinterface

// File: rtl/display_scan_ctrl_bcd_dabble_seq.sv
// rtl/display_scan_ctrl_bcd_dabble_seq.sv - serial double-dabble binary to BCD converter
module bcd_dabble_seq #(
  parameter int WIDTH      = 16,
  parameter int BCD_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WIDTH-1:0]        bin,
  output logic                    done,
  output logic [BCD_DIGITS*4-1:0] bcd
);

  localparam int BCD_W = BCD_DIGITS * 4;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BCD_W-1:0] adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  // Add-3 correction on every nibble >= 5, then shift one binary bit into the BCD field.
  always_comb begin
    adj   = bcd_q;
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    run_d = run_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
    if (start) begin
      bin_d = bin;
      bcd_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      bcd_d = {adj[BCD_W-2:0], bin_q[WIDTH-1]};
      bin_d = {bin_q[WIDTH-2:0], 1'b0};
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        run_d = 1'b0;
      end
    end
  end

  // Converter state; the result stays in bcd_q after the last shift until the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  // High during the cycle whose closing edge performs the final shift, so the
  // caller can leave its convert phase on that same edge.
  assign done = run_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign bcd  = bcd_q;

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - signed value to multiplexed 7-segment digit sequencer
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int NDIG        = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic               clk,
  input  logic               rst,
  display_scan_ctrl_if.slave bus
);

  localparam int BCD_DIGITS = bcd_digits(WIDTH);
  localparam int BCD_W      = BCD_DIGITS * 4;
  localparam int RCNT_W     = $clog2(REFRESH_DIV);
  localparam int IDX_W      = $clog2(NDIG);

  scan_state_t      state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             sign_q, sign_d;
  logic [BCD_W-1:0] disp_bcd_q, disp_bcd_d;
  logic             disp_sign_q, disp_sign_d;

  logic             accept;
  logic [WIDTH-1:0] mag;
  logic             conv_done;
  logic [BCD_W-1:0] conv_bcd;

  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NDIG-1:0]   anode_q, anode_d;
  logic [3:0]        digito_q, digito_d;
  logic [3:0]        sel_digit;
  int                msd;
  int                pos;

  assign accept = bus.in_valid & in_ready_q;

  // Two's-complement magnitude; the most negative value maps onto 2^(WIDTH-1) unsigned.
  assign mag = bus.in_data[WIDTH-1] ? ((~bus.in_data) + WIDTH'(1)) : bus.in_data;

  bcd_dabble_seq #(
    .WIDTH      (WIDTH),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_dabble (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .bin   (mag),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Handshake next-state: display registers only change in COMMIT, so the old value
  // stays on the digits for the whole conversion.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    sign_d      = sign_q;
    disp_bcd_d  = disp_bcd_q;
    disp_sign_d = disp_sign_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_CONVERT;
          in_ready_d = 1'b0;
          sign_d     = bus.in_data[WIDTH-1];
        end
      end
      S_CONVERT: begin
        if (conv_done) begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        disp_bcd_d  = conv_bcd;
        disp_sign_d = sign_q & (conv_bcd != '0);
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
      end
      default: begin
        state_d    = S_IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  // Handshake FSM and display registers; rst aborts a conversion and clears the display.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      sign_q      <= 1'b0;
      disp_bcd_q  <= '0;
      disp_sign_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      sign_q      <= sign_d;
      disp_bcd_q  <= disp_bcd_d;
      disp_sign_q <= disp_sign_d;
    end
  end

  // Refresh divider and digit index; free-running regardless of conversions.
  always_comb begin
    rcnt_d = rcnt_q + RCNT_W'(1);
    idx_d  = idx_q;
    if (rcnt_q == RCNT_W'(REFRESH_DIV - 1)) begin
      rcnt_d = '0;
      idx_d  = (idx_q == IDX_W'(NDIG - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Blanking and digit select for the position currently addressed by idx_q.
  always_comb begin
    msd       = 0;
    pos       = int'(idx_q);
    sel_digit = DIG_ZERO;
    anode_d   = '1;
    digito_d  = DIG_ZERO;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (disp_bcd_q[i*4 +: 4] != 4'd0) begin
        msd = i;
      end
      if (pos == i) begin
        sel_digit = disp_bcd_q[i*4 +: 4];
      end
    end
    if (pos <= msd) begin
      anode_d  = ~(NDIG'(1) << idx_q);
      digito_d = sel_digit;
    end else if (disp_sign_q && (pos == msd + 1)) begin
      anode_d  = ~(NDIG'(1) << idx_q);
      digito_d = DIG_DASH;
    end
  end

  // Scan registers; anode/digito trail idx by one cycle and only change on an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt_q   <= '0;
      idx_q    <= '0;
      anode_q  <= '1;
      digito_q <= DIG_ZERO;
    end else begin
      rcnt_q   <= rcnt_d;
      idx_q    <= idx_d;
      anode_q  <= anode_d;
      digito_q <= digito_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.busy     = ~in_ready_q;
  assign bus.anode    = anode_q;
  assign bus.digito   = digito_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - directed self-checking bench for display_scan_ctrl
module tb_display_scan_ctrl;

  typedef int code8_t [8];
  localparam int B = -1;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  display_scan_ctrl_if #(.WIDTH(16), .NDIG(8)) bus ();

  display_scan_ctrl #(
    .WIDTH       (16),
    .NDIG        (8),
    .REFRESH_DIV (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // Expected code at position p for value v, or -1 when the position is blank.
  function automatic int code_at(input int v, input int p);
    int m;
    int msd;
    int d [8];
    m   = (v < 0) ? -v : v;
    msd = 0;
    for (int i = 0; i < 8; i++) begin
      d[i] = m % 10;
      m    = m / 10;
      if (d[i] != 0) msd = i;
    end
    if (p <= msd) return d[p];
    if ((p == msd + 1) && (v < 0)) return 15;
    return -1;
  endfunction

  // Called at a negedge with in_ready high; returns at the negedge where in_ready rises.
  task automatic send(input int v);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'(v);
    chk("send_ready", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("send_busy", bus.busy, 1);
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("send_latency", n, 17);
  endtask

  // Watches one full scan frame (32 cycles) and checks each position's lit time and code.
  task automatic check_frame(input string tag, input code8_t e);
    int lit [8];
    int seen [8];
    int found;
    int badv;
    int illegal;
    int blank_nz;
    badv = 0;
    illegal = 0;
    blank_nz = 0;
    for (int p = 0; p < 8; p++) begin
      lit[p]  = 0;
      seen[p] = -1;
    end
    repeat (32) begin
      @(negedge clk);
      found = -1;
      for (int p = 0; p < 8; p++) begin
        if (bus.anode == ~(8'(1) << p)) found = p;
      end
      if (found >= 0) begin
        lit[found]++;
        if (seen[found] < 0) seen[found] = int'(bus.digito);
        else if (seen[found] != int'(bus.digito)) badv++;
      end else if (bus.anode == 8'hFF) begin
        if (bus.digito != 4'd0) blank_nz++;
      end else begin
        illegal++;
      end
    end
    for (int p = 0; p < 8; p++) begin
      chk($sformatf("%s_lit%0d", tag, p), lit[p], (e[p] < 0) ? 0 : 4);
      if (e[p] >= 0) chk($sformatf("%s_dig%0d", tag, p), seen[p], e[p]);
    end
    chk({tag, "_stable"}, badv, 0);
    chk({tag, "_anode_legal"}, illegal, 0);
    chk({tag, "_blank_zero"}, blank_nz, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    code8_t e;
    int     shown;
    int     pend_val;
    int     pend_c;
    int     last_acc;
    int     n_acc;
    int     errs;
    int     v;
    int     p_lit;
    int     ex;
    int     n;
    logic   acc;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_anode", bus.anode, 8'hFF);
    chk("rst_digito", bus.digito, 0);
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0;

    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      chk($sformatf("boot_anode%0d", c), bus.anode, (c < 4) ? 8'hFE : 8'hFF);
      chk($sformatf("boot_digito%0d", c), bus.digito, 0);
    end

    e = '{4, 3, 2, 1, B, B, B, B};   send(1234);   check_frame("v1234", e);
    e = '{8, 6, 7, 2, 3, 15, B, B};  send(-32768); check_frame("vmin", e);
    e = '{5, 15, B, B, B, B, B, B};  send(-5);     check_frame("vm5", e);
    e = '{0, B, B, B, B, B, B, B};   send(0);      check_frame("v0", e);
    e = '{7, 6, 7, 2, 3, B, B, B};   send(32767);  check_frame("vmax", e);
    e = '{1, 15, B, B, B, B, B, B};  send(-1);     check_frame("vm1", e);
    e = '{0, 0, 1, 15, B, B, B, B};  send(-100);   check_frame("vm100", e);
    e = '{0, 1, B, B, B, B, B, B};   send(10);     check_frame("v10", e);

    // in_valid held high with data changing every cycle
    shown    = 10;
    pend_val = 0;
    pend_c   = -100;
    last_acc = -1;
    n_acc    = 0;
    errs     = 0;
    for (int c = 0; c < 90; c++) begin
      v = (((c / 18) % 2) == 1) ? -(300 + 7 * c) : (300 + 7 * c);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(v);
      acc = bus.in_ready;
      @(posedge clk);
      if (c - pend_c == 18) shown = pend_val;
      if (acc) begin
        if (last_acc >= 0) chk("acc_gap", c - last_acc, 18);
        last_acc = c;
        n_acc++;
        pend_val = v;
        pend_c   = c;
      end
      @(negedge clk);
      p_lit = -2;
      if (bus.anode == 8'hFF) p_lit = -1;
      for (int p = 0; p < 8; p++) begin
        if (bus.anode == ~(8'(1) << p)) p_lit = p;
      end
      if (p_lit == -2) begin
        errs++;
      end else if (p_lit == -1) begin
        if (bus.digito != 4'd0) errs++;
      end else begin
        ex = code_at(shown, p_lit);
        if (ex < 0 || bus.digito != 4'(ex)) errs++;
      end
    end
    bus.in_valid = 1'b0;
    chk("acc_count", n_acc, 5);
    chk("hold_errs", errs, 0);
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("drain_ready", bus.in_ready, 1);

    // rst pulsed partway through converting 999
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd999;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("rc_busy", bus.busy, 1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rc_rst_anode", bus.anode, 8'hFF);
    chk("rc_rst_ready", bus.in_ready, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("rc_ready", bus.in_ready, 1);
    chk("rc_anode", bus.anode, 8'hFE);
    chk("rc_digito", bus.digito, 0);
    e = '{0, B, B, B, B, B, B, B};
    check_frame("rc", e);
    chk("rc_idle", bus.in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
